// File: rtl/exc_ctrl_if.sv
// Signal bundle between the MEM stage / CP0 and the exception controller.
// The controller binds the slave modport; the pipeline side binds master.
interface exc_ctrl_if;
  logic        mem_valid;
  logic        mem_adv;
  logic [31:0] mem_pc;
  logic        mem_bd;
  logic [6:0]  mem_exc;
  logic [31:0] mem_if_vaddr;
  logic [31:0] mem_ls_vaddr;
  logic        mem_eret;
  logic [5:0]  hw_int;
  logic [1:0]  sw_int;
  logic [7:0]  int_mask;
  logic        allow_int;
  logic        boot_exp_vec;
  logic        special_int_vec;
  logic [19:0] ebase;
  logic [31:0] epc;
  logic        en_exp;
  logic [4:0]  exp_code;
  logic [31:0] exp_epc;
  logic        exp_bd;
  logic [31:0] exp_bad_vaddr;
  logic        exp_badv_we;
  logic        clean_exl;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ack;

  modport slave (
    input  mem_valid, mem_adv, mem_pc, mem_bd, mem_exc, mem_if_vaddr, mem_ls_vaddr, mem_eret,
           hw_int, sw_int, int_mask, allow_int, boot_exp_vec, special_int_vec, ebase, epc,
           redirect_ack,
    output en_exp, exp_code, exp_epc, exp_bd, exp_bad_vaddr, exp_badv_we, clean_exl, flush,
           redirect_valid, redirect_pc
  );

  modport master (
    output mem_valid, mem_adv, mem_pc, mem_bd, mem_exc, mem_if_vaddr, mem_ls_vaddr, mem_eret,
           hw_int, sw_int, int_mask, allow_int, boot_exp_vec, special_int_vec, ebase, epc,
           redirect_ack,
    input  en_exp, exp_code, exp_epc, exp_bd, exp_bad_vaddr, exp_badv_we, clean_exl, flush,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: picks one cause for the MEM instruction, writes CP0,
// flushes the pipeline and holds the PC redirect until IF acknowledges it.
module exc_ctrl #(
  parameter logic [31:0] BOOT_VEC = 32'hBFC0_0380,
  parameter logic [11:0] GEN_OFS  = 12'h180,
  parameter logic [11:0] IV_OFS   = 12'h200
) (
  input  logic        clk,
  input  logic        rst,
  exc_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StTake, StHold} state_e;
  state_e state_q, state_d;

  logic        int_pend, take, sel_eret, sel_badv_we;
  logic [4:0]  sel_code;
  logic [31:0] sel_badv, sel_epc, sel_vec;

  logic        eret_q, badv_we_q, bd_q;
  logic [4:0]  code_q;
  logic [31:0] epc_q, badv_q, redir_q;

  logic en_exp, clean_exl, badv_we, flush, redirect_valid;

  // Cause selection, fixed priority; ERET only when nothing else is pending.
  always_comb begin
    int_pend    = bus.allow_int & (|({bus.hw_int, bus.sw_int} & bus.int_mask));
    take        = bus.mem_valid & bus.mem_adv & (int_pend | (|bus.mem_exc) | bus.mem_eret);
    sel_code    = 5'd0;
    sel_badv_we = 1'b0;
    sel_badv    = 32'h0;
    sel_eret    = 1'b0;
    if (int_pend) begin
      sel_code = 5'd0;
    end else if (bus.mem_exc[6]) begin
      sel_code    = 5'd4;
      sel_badv_we = 1'b1;
      sel_badv    = bus.mem_if_vaddr;
    end else if (bus.mem_exc[5]) begin
      sel_code = 5'd10;
    end else if (bus.mem_exc[4]) begin
      sel_code = 5'd12;
    end else if (bus.mem_exc[3]) begin
      sel_code = 5'd8;
    end else if (bus.mem_exc[2]) begin
      sel_code = 5'd9;
    end else if (bus.mem_exc[1]) begin
      sel_code    = 5'd4;
      sel_badv_we = 1'b1;
      sel_badv    = bus.mem_ls_vaddr;
    end else if (bus.mem_exc[0]) begin
      sel_code    = 5'd5;
      sel_badv_we = 1'b1;
      sel_badv    = bus.mem_ls_vaddr;
    end else begin
      sel_eret = 1'b1;
    end
    sel_epc = bus.mem_bd ? bus.mem_pc - 32'd4 : bus.mem_pc;
    if (sel_eret) begin
      sel_vec = bus.epc;
    end else if (bus.boot_exp_vec) begin
      sel_vec = BOOT_VEC;
    end else begin
      sel_vec = {bus.ebase, 12'h000} +
                {20'h0, (int_pend & bus.special_int_vec) ? IV_OFS : GEN_OFS};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eret_q    <= 1'b0;
      badv_we_q <= 1'b0;
      bd_q      <= 1'b0;
      code_q    <= 5'd0;
      epc_q     <= 32'h0;
      badv_q    <= 32'h0;
      redir_q   <= 32'h0;
    end else if (state_q == StIdle && take) begin
      eret_q    <= sel_eret;
      badv_we_q <= sel_badv_we;
      bd_q      <= bus.mem_bd;
      code_q    <= sel_code;
      epc_q     <= sel_epc;
      badv_q    <= sel_badv;
      redir_q   <= sel_vec;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    en_exp         = 1'b0;
    clean_exl      = 1'b0;
    badv_we        = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    case (state_q)
      StIdle: begin
        if (take) state_d = StTake;
      end
      StTake: begin
        en_exp         = ~eret_q;
        clean_exl      = eret_q;
        badv_we        = badv_we_q;
        flush          = 1'b1;
        redirect_valid = 1'b1;
        state_d        = bus.redirect_ack ? StIdle : StHold;
      end
      StHold: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        if (bus.redirect_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.en_exp         = en_exp;
  assign bus.clean_exl      = clean_exl;
  assign bus.exp_badv_we    = badv_we;
  assign bus.flush          = flush;
  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_pc    = redir_q;
  assign bus.exp_code       = code_q;
  assign bus.exp_epc        = epc_q;
  assign bus.exp_bd         = bd_q;
  assign bus.exp_bad_vaddr  = badv_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed scenarios with literal expectations plus random traffic
// compared every cycle against a transaction-level model.
module tb_exc_ctrl;
  localparam logic [31:0] BOOT_VEC = 32'hBFC0_0380;
  localparam int CODE_OF [7] = '{5, 4, 9, 8, 12, 10, 4};  // ExcCode by mem_exc bit index

  typedef struct packed {
    logic        take;
    logic        eret;
    logic [4:0]  code;
    logic [31:0] epc;
    logic        bd;
    logic [31:0] badv;
    logic        badv_we;
    logic [31:0] vec;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  exc_ctrl_if bus ();

  exc_ctrl #(
    .BOOT_VEC(BOOT_VEC),
    .GEN_OFS (12'h180),
    .IV_OFS  (12'h200)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // What the pending exception would be if taken from the current inputs.
  rec_t cur;
  logic ip, found;
  always_comb begin
    cur   = '0;
    ip    = bus.allow_int && (({bus.hw_int, bus.sw_int} & bus.int_mask) != 8'h0);
    found = ip;
    cur.take = bus.mem_valid && bus.mem_adv && (ip || bus.mem_exc != 7'h0 || bus.mem_eret);
    cur.epc  = bus.mem_pc - (bus.mem_bd ? 32'd4 : 32'd0);
    cur.bd   = bus.mem_bd;
    for (int b = 6; b >= 0; b--) begin
      if (!found && bus.mem_exc[b]) begin
        found       = 1'b1;
        cur.code    = 5'(CODE_OF[b]);
        cur.badv_we = (b == 6) || (b <= 1);
        cur.badv    = (b == 6) ? bus.mem_if_vaddr : bus.mem_ls_vaddr;
      end
    end
    cur.eret = !found;
    if (cur.eret) cur.vec = bus.epc;
    else if (bus.boot_exp_vec) cur.vec = BOOT_VEC;
    else cur.vec = (32'(bus.ebase) << 12) + ((ip && bus.special_int_vec) ? 32'h200 : 32'h180);
  end

  // Transaction tracker: busy from the accepting edge until the edge that sees an ack.
  logic m_busy, m_first;
  rec_t m_rec;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy  <= 1'b0;
      m_first <= 1'b0;
      m_rec   <= '0;
    end else if (!m_busy) begin
      if (cur.take) begin
        m_busy  <= 1'b1;
        m_first <= 1'b1;
        m_rec   <= cur;
      end
    end else begin
      m_first <= 1'b0;
      if (bus.redirect_ack) m_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chkb("en_exp", bus.en_exp, m_busy && m_first && !m_rec.eret);
      chkb("clean_exl", bus.clean_exl, m_busy && m_first && m_rec.eret);
      chkb("badv_we", bus.exp_badv_we, m_busy && m_first && m_rec.badv_we);
      chkb("flush", bus.flush, m_busy);
      chkb("redirect_valid", bus.redirect_valid, m_busy);
      if (m_busy) chk("redirect_pc", bus.redirect_pc, m_rec.vec);
      if (m_busy && m_first && !m_rec.eret) begin
        chk("exp_code", 32'(bus.exp_code), 32'(m_rec.code));
        chk("exp_epc", bus.exp_epc, m_rec.epc);
        chkb("exp_bd", bus.exp_bd, m_rec.bd);
        if (m_rec.badv_we) chk("exp_bad_vaddr", bus.exp_bad_vaddr, m_rec.badv);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.mem_valid       = 1'b0;
    bus.mem_adv         = 1'b0;
    bus.mem_pc          = 32'h0;
    bus.mem_bd          = 1'b0;
    bus.mem_exc         = 7'h0;
    bus.mem_if_vaddr    = 32'h0;
    bus.mem_ls_vaddr    = 32'h0;
    bus.mem_eret        = 1'b0;
    bus.hw_int          = 6'h0;
    bus.sw_int          = 2'h0;
    bus.int_mask        = 8'h0;
    bus.allow_int       = 1'b0;
    bus.boot_exp_vec    = 1'b0;
    bus.special_int_vec = 1'b0;
    bus.ebase           = 20'h0;
    bus.epc             = 32'h0;
    bus.redirect_ack    = 1'b0;
  endtask

  task automatic release_redirect();
    bus.redirect_ack = 1'b1;
    cyc();
    bus.redirect_ack = 1'b0;
    chkb("redirect_released", bus.redirect_valid, 1'b0);
  endtask

  task automatic fire();
    bus.mem_valid = 1'b1;
    bus.mem_adv   = 1'b1;
  endtask

  initial begin
    quiet();
    repeat (3) cyc();
    chkb("rst_en_exp", bus.en_exp, 1'b0);
    chkb("rst_flush", bus.flush, 1'b0);
    chkb("rst_redirect_valid", bus.redirect_valid, 1'b0);
    chk("rst_redirect_pc", bus.redirect_pc, 32'h0);
    chk("rst_exp_epc", bus.exp_epc, 32'h0);
    chkb("rst_clean_exl", bus.clean_exl, 1'b0);
    rst = 1'b1;
    cyc();

    // RI in boot mode
    fire();
    bus.mem_pc = 32'h8000_1000;
    bus.mem_exc = 7'b010_0000;
    bus.boot_exp_vec = 1'b1;
    cyc();
    quiet();
    chkb("ri_en_exp", bus.en_exp, 1'b1);
    chk("ri_code", 32'(bus.exp_code), 32'd10);
    chk("ri_epc", bus.exp_epc, 32'h8000_1000);
    chk("ri_redirect", bus.redirect_pc, 32'hBFC0_0380);
    chkb("ri_badv_we", bus.exp_badv_we, 1'b0);
    release_redirect();

    // AdEL load in a delay slot
    fire();
    bus.mem_pc = 32'h8000_2004;
    bus.mem_bd = 1'b1;
    bus.mem_exc = 7'b000_0010;
    bus.mem_ls_vaddr = 32'h0000_0003;
    bus.ebase = 20'h80000;
    cyc();
    quiet();
    chk("adel_code", 32'(bus.exp_code), 32'd4);
    chk("adel_epc", bus.exp_epc, 32'h8000_2000);
    chkb("adel_bd", bus.exp_bd, 1'b1);
    chk("adel_badv", bus.exp_bad_vaddr, 32'h3);
    chkb("adel_badv_we", bus.exp_badv_we, 1'b1);
    chk("adel_redirect", bus.redirect_pc, 32'h8000_0180);
    release_redirect();

    // Interrupt beats overflow, IV vector
    fire();
    bus.hw_int = 6'b10_0000;
    bus.int_mask = 8'h80;
    bus.allow_int = 1'b1;
    bus.special_int_vec = 1'b1;
    bus.mem_exc = 7'b001_0000;
    bus.ebase = 20'h80000;
    cyc();
    quiet();
    chk("int_code", 32'(bus.exp_code), 32'd0);
    chk("int_redirect", bus.redirect_pc, 32'h8000_0200);
    chkb("int_badv_we", bus.exp_badv_we, 1'b0);
    release_redirect();

    // ERET, ack withheld for three cycles
    fire();
    bus.mem_eret = 1'b1;
    bus.epc = 32'h8000_3000;
    cyc();
    quiet();
    chkb("eret_clean_exl", bus.clean_exl, 1'b1);
    chkb("eret_en_exp", bus.en_exp, 1'b0);
    chk("eret_redirect", bus.redirect_pc, 32'h8000_3000);
    for (int i = 0; i < 4; i++) begin
      chkb("eret_hold", bus.redirect_valid, 1'b1);
      if (i == 3) bus.redirect_ack = 1'b1;
      cyc();
    end
    chkb("eret_released", bus.redirect_valid, 1'b0);
    bus.redirect_ack = 1'b0;

    // SYSCALL stalled two cycles
    bus.mem_valid = 1'b1;
    bus.mem_exc = 7'b000_1000;
    bus.boot_exp_vec = 1'b1;
    cyc();
    chkb("stall_1", bus.en_exp, 1'b0);
    cyc();
    chkb("stall_2", bus.en_exp, 1'b0);
    bus.mem_adv = 1'b1;
    cyc();
    quiet();
    chkb("sys_en_exp", bus.en_exp, 1'b1);
    chk("sys_code", 32'(bus.exp_code), 32'd8);
    release_redirect();

    // EPC wrap-around and ack in the TAKE cycle
    fire();
    bus.mem_pc = 32'h0;
    bus.mem_bd = 1'b1;
    bus.mem_exc = 7'b000_0001;
    bus.mem_ls_vaddr = 32'h0000_1234;
    bus.boot_exp_vec = 1'b1;
    bus.redirect_ack = 1'b1;
    cyc();
    quiet();
    bus.redirect_ack = 1'b1;
    chk("wrap_epc", bus.exp_epc, 32'hFFFF_FFFC);
    chk("ades_code", 32'(bus.exp_code), 32'd5);
    chk("ades_badv", bus.exp_bad_vaddr, 32'h1234);
    cyc();
    chkb("skip_hold", bus.redirect_valid, 1'b0);
    bus.redirect_ack = 1'b0;

    // Reset while holding the redirect
    fire();
    bus.mem_exc = 7'b000_0100;
    bus.boot_exp_vec = 1'b1;
    cyc();
    quiet();
    cyc();
    chkb("hold_before_rst", bus.redirect_valid, 1'b1);
    #2 rst = 1'b0;
    #1;
    chkb("rst_async_redirect", bus.redirect_valid, 1'b0);
    chkb("rst_async_flush", bus.flush, 1'b0);
    cyc();
    rst = 1'b1;
    fire();
    bus.mem_exc = 7'b001_0000;
    bus.boot_exp_vec = 1'b1;
    cyc();
    quiet();
    chkb("post_rst_en_exp", bus.en_exp, 1'b1);
    chk("post_rst_code", 32'(bus.exp_code), 32'd12);
    release_redirect();

    // Random traffic, checked by the per-cycle compare process
    repeat (3000) begin
      bus.mem_valid       = ($urandom_range(0, 3) != 0);
      bus.mem_adv         = ($urandom_range(0, 3) != 0);
      bus.mem_pc          = ($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom & 32'hFFFF_FFFC);
      bus.mem_bd          = 1'($urandom);
      bus.mem_exc         = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h0;
      bus.mem_if_vaddr    = $urandom;
      bus.mem_ls_vaddr    = $urandom;
      bus.mem_eret        = ($urandom_range(0, 5) == 0);
      bus.hw_int          = 6'($urandom);
      bus.sw_int          = 2'($urandom);
      bus.int_mask        = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'h0;
      bus.allow_int       = ($urandom_range(0, 2) == 0);
      bus.boot_exp_vec    = 1'($urandom);
      bus.special_int_vec = 1'($urandom);
      bus.ebase           = 20'($urandom);
      bus.epc             = $urandom;
      bus.redirect_ack    = ($urandom_range(0, 2) == 0);
      cyc();
    end
    quiet();
    bus.redirect_ack = 1'b1;
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
